// File: rtl/note_sequencer.sv
// Note sequencer: steps through a small note RAM and drives one wave_generator voice.
// Optional portamento between notes is enabled by defining NOTE_SEQ_GLIDE_EN.
module note_sequencer #(
    parameter int unsigned CPU_CLOCK_FREQ = 100_000_000,
    parameter int unsigned TICK_HZ        = 1000,
    parameter int unsigned DEPTH          = 16,
    localparam int unsigned AW            = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [14:0]   wr_freq,
    input  logic [11:0]   wr_on,
    input  logic [11:0]   wr_off,
    input  logic [AW:0]   length,
    input  logic          loop,
    input  logic          start,
    input  logic          stop,
    output logic [14:0]   frequency,
    output logic          press,
    output logic          busy,
    output logic [AW-1:0] step,
    output logic          done
);

    localparam int unsigned CPT = CPU_CLOCK_FREQ / TICK_HZ;
    localparam int unsigned PW  = (CPT > 1) ? $clog2(CPT) : 1;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ON, S_OFF, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d, presc_run;
    logic [11:0]   cnt_q, cnt_d;
    logic [11:0]   off_q, off_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] step_q, step_d;
    logic [14:0]   freq_q, freq_d;
    logic          press_q, busy_q, done_q;
    logic          tick, last, adv;

    logic [38:0]   mem [DEPTH];
    logic [38:0]   entry;
    logic [14:0]   e_freq;
    logic [11:0]   e_on, e_off;

`ifdef NOTE_SEQ_GLIDE_EN
    logic [14:0]   target_q, target_d;
    logic          first_q, first_d;
    logic          glide_pending;
    logic [14:0]   diff, amt;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_freq, wr_on, wr_off};
        end
    end

    assign entry  = mem[step_q];
    assign e_freq = entry[38:24];
    assign e_on   = entry[23:12];
    assign e_off  = entry[11:0];

    assign tick      = (presc_q == PW'(CPT - 1));
    assign presc_run = tick ? '0 : presc_q + PW'(1);
    assign last      = ({1'b0, step_q} == len_q - (AW + 1)'(1));

`ifdef NOTE_SEQ_GLIDE_EN
    assign glide_pending = (freq_q != target_q);
    assign diff = (target_q > freq_q) ? target_q - freq_q : freq_q - target_q;
    assign amt  = (diff > 15'd64) ? 15'd64 : diff;
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        len_d   = len_q;
        step_d  = step_q;
        freq_d  = freq_q;
        adv     = 1'b0;
`ifdef NOTE_SEQ_GLIDE_EN
        target_d = target_q;
        first_d  = first_q;
        if (tick && state_q != S_LOAD && glide_pending) begin
            freq_d = (target_q > freq_q) ? freq_q + amt : freq_q - amt;
        end
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                presc_d = '0;
`ifdef NOTE_SEQ_GLIDE_EN
                if (glide_pending) presc_d = presc_run;
`endif
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end else if (start && !stop && length != '0) begin
                    state_d = S_LOAD;
                    step_d  = '0;
                    presc_d = '0;
                    len_d   = (length > DEPTH_L) ? DEPTH_L : length;
`ifdef NOTE_SEQ_GLIDE_EN
                    first_d = 1'b1;
`endif
                end
            end
            S_LOAD: begin
                presc_d = '0;
                off_d   = e_off;
`ifdef NOTE_SEQ_GLIDE_EN
                target_d = e_freq;
                first_d  = 1'b0;
                if (first_q) freq_d = e_freq;
`else
                freq_d = e_freq;
`endif
                if (e_on != '0) begin
                    state_d = S_ON;
                    cnt_d   = e_on;
                end else if (e_off != '0) begin
                    state_d = S_OFF;
                    cnt_d   = e_off;
                end else begin
                    adv = 1'b1;
                end
            end
            S_ON: begin
                presc_d = presc_run;
                if (tick) begin
                    if (cnt_q == 12'd1) begin
                        // A zero release gap skips OFF so the gap is just the LOAD cycle.
                        if (off_q != '0) begin
                            state_d = S_OFF;
                            cnt_d   = off_q;
                        end else begin
                            adv = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 12'd1;
                    end
                end
            end
            S_OFF: begin
                presc_d = presc_run;
                if (tick) begin
                    if (cnt_q == 12'd1) adv = 1'b1;
                    else                cnt_d = cnt_q - 12'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            if (!last) begin
                step_d  = step_q + AW'(1);
                state_d = S_LOAD;
            end else if (loop) begin
                step_d  = '0;
                state_d = S_LOAD;
            end else begin
                state_d = S_DONE;
            end
        end

        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            step_d  = step_q;
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            cnt_q   <= '0;
            off_q   <= '0;
            len_q   <= '0;
            step_q  <= '0;
            freq_q  <= '0;
            press_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            len_q   <= len_d;
            step_q  <= step_d;
            freq_q  <= freq_d;
            press_q <= (state_d == S_ON);
            busy_q  <= (state_d == S_LOAD) || (state_d == S_ON) || (state_d == S_OFF);
            done_q  <= (state_d == S_DONE);
        end
    end

`ifdef NOTE_SEQ_GLIDE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= '0;
            first_q  <= 1'b1;
        end else begin
            target_q <= target_d;
            first_q  <= first_d;
        end
    end
`endif

    assign frequency = freq_q;
    assign press     = press_q;
    assign busy      = busy_q;
    assign step      = step_q;
    assign done      = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with CPT=10, DEPTH=4.
module tb_note_sequencer;

    localparam int LIM = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [14:0] wr_freq = '0;
    logic [11:0] wr_on = '0;
    logic [11:0] wr_off = '0;
    logic [2:0]  length = '0;
    logic        loop = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [14:0] frequency;
    logic        press;
    logic        busy;
    logic [1:0]  step;
    logic        done;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    note_sequencer #(
        .CPU_CLOCK_FREQ(1000),
        .TICK_HZ(100),
        .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq), .wr_on(wr_on), .wr_off(wr_off),
        .length(length), .loop(loop), .start(start), .stop(stop),
        .frequency(frequency), .press(press), .busy(busy), .step(step), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic write_entry(input int unsigned a, input int unsigned f,
                               input int unsigned on, input int unsigned off);
        wr_en = 1'b1; wr_addr = 2'(a); wr_freq = 15'(f); wr_on = 12'(on); wr_off = 12'(off);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_press(input logic lvl, input string tag);
        int n = 0;
        while (press !== lvl && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (press !== lvl) check(tag, press, lvl);
    endtask

    task automatic count_high(output int w);
        w = 0;
        while (press === 1'b1 && w < LIM) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic single_note(input string p);
        int w, n, d0;
        write_entry(0, 2000, 3, 2);
        length = 3'd1; loop = 1'b0;
        d0 = done_seen;
        pulse_start();
        check({p, "_load_busy"}, busy, 1);
        check({p, "_load_press"}, press, 0);
        @(negedge clk);
        check({p, "_freq"}, frequency, 2000);
        count_high(w);
        check({p, "_press_width"}, w, 30);
        n = 0;
        while (done !== 1'b1 && n < LIM) begin
            @(negedge clk);
            n++;
        end
        check({p, "_done_delay"}, n, 20);
        check({p, "_done_busy"}, busy, 0);
        @(negedge clk);
        check({p, "_after_busy"}, busy, 0);
        check({p, "_after_done"}, done, 0);
        check({p, "_freq_hold"}, frequency, 2000);
        check({p, "_done_count"}, done_seen - d0, 1);
    endtask

    initial begin
        int w, g, d0;
        logic saw;

        repeat (2) @(negedge clk);
        check("rst_press", press, 0);
        check("rst_busy", busy, 0);
        check("rst_freq", frequency, 0);
        check("rst_step", step, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        single_note("single");

        // Three steps with a rest; a start during the run must be ignored.
        write_entry(0, 1000, 2, 1);
        write_entry(1, 15'h7FFF, 0, 2);
        write_entry(2, 500, 1, 0);
        length = 3'd3; loop = 1'b0;
        d0 = done_seen;
        pulse_start();
        length = 3'd1;
        wait_press(1'b1, "seq_rise0");
        check("seq_step0", step, 0);
        check("seq_freq0", frequency, 1000);
        w = 0;
        while (press === 1'b1 && w < LIM) begin
            w++;
            start = (w == 5);
            @(negedge clk);
        end
        start = 1'b0;
        check("seq_width0", w, 20);
        g = 0; saw = 1'b0;
        while (press === 1'b0 && g < LIM) begin
            if (step == 2'd1 && frequency == 15'h7FFF) saw = 1'b1;
            g++;
            @(negedge clk);
        end
        check("seq_gap", g, 32);
        check("seq_rest_freq", saw, 1);
        check("seq_step2", step, 2);
        check("seq_freq2", frequency, 500);
        count_high(w);
        check("seq_width2", w, 10);
        check("seq_done_at_fall", done, 1);
        check("seq_step_held", step, 2);
        repeat (20) @(negedge clk);
        check("seq_done_count", done_seen - d0, 1);

        // Looping run, rewrite of the active entry, then stop.
        write_entry(0, 300, 2, 1);
        write_entry(1, 400, 1, 1);
        length = 3'd2; loop = 1'b1;
        d0 = done_seen;
        pulse_start();
        wait_press(1'b1, "loop_rise0");
        check("loop_step0", step, 0);
        check("loop_freq0", frequency, 300);
        write_entry(0, 333, 2, 1);
        check("loop_freq0_kept", frequency, 300);
        wait_press(1'b0, "loop_fall0");
        wait_press(1'b1, "loop_rise1");
        check("loop_step1", step, 1);
        check("loop_freq1", frequency, 400);
        wait_press(1'b0, "loop_fall1");
        wait_press(1'b1, "loop_rise2");
        check("loop_wrap_step", step, 0);
        check("loop_new_freq", frequency, 333);
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_press", press, 0);
        check("stop_busy", busy, 0);
        repeat (30) @(negedge clk);
        check("stop_idle_busy", busy, 0);
        check("stop_step", step, 0);
        check("stop_freq", frequency, 333);
        check("stop_no_done", done_seen - d0, 0);
        loop = 1'b0;

        // start with length=0, then start+stop together, both from IDLE.
        d0 = done_seen;
        length = 3'd0;
        pulse_start();
        check("len0_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("len0_busy_later", busy, 0);
        check("len0_press", press, 0);
        length = 3'd1;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("startstop_busy_later", busy, 0);
        check("startstop_press", press, 0);
        check("edge_no_done", done_seen - d0, 0);

        // Asynchronous reset in the middle of a note.
        write_entry(0, 2000, 3, 2);
        length = 3'd1;
        pulse_start();
        wait_press(1'b1, "arst_rise");
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_press", press, 0);
        check("arst_busy", busy, 0);
        check("arst_freq", frequency, 0);
        check("arst_step", step, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        single_note("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
